// File: rtl/ch0re_ex_stage.sv
// ch0re execute stage: operand forwarding, ALU drive, branch/jump resolution,
// EX/MEM pipeline register and one-cycle front-end redirect.

package ch0re_pkg;
    localparam int unsigned ALU_W = 64;
    localparam int unsigned REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_GE   = 4'd13,
        ALU_LTU  = 4'd14,
        ALU_GEU  = 4'd15
    } alu_op_e;
endpackage

interface ch0re_alu_intf;
    ch0re_pkg::alu_op_e             i_op;
    logic [ch0re_pkg::ALU_W-1:0]    i_s1;
    logic [ch0re_pkg::ALU_W-1:0]    i_s2;
    logic [ch0re_pkg::ALU_W-1:0]    o_res;
    logic                           o_flag_zero;
    logic                           o_flag_lt;

    modport initiator (output i_op, i_s1, i_s2, input o_res, o_flag_zero, o_flag_lt);
    modport target    (input i_op, i_s1, i_s2, output o_res, o_flag_zero, o_flag_lt);
endinterface

module ch0re_ex_stage
    import ch0re_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_id_valid,
    output logic                o_id_ready,
    input  alu_op_e             i_id_op,
    input  logic [XLEN-1:0]     i_id_pc,
    input  logic [XLEN-1:0]     i_id_rs1,
    input  logic [XLEN-1:0]     i_id_rs2,
    input  logic [XLEN-1:0]     i_id_imm,
    input  logic [REG_W-1:0]    i_id_rs1_idx,
    input  logic [REG_W-1:0]    i_id_rs2_idx,
    input  logic [REG_W-1:0]    i_id_rd,
    input  logic                i_id_src1_pc,
    input  logic                i_id_src2_imm,
    input  logic                i_id_is_branch,
    input  logic                i_id_is_jump,
    input  logic                i_id_wb_en,
    input  logic                i_mem_fwd_en,
    input  logic [REG_W-1:0]    i_mem_fwd_rd,
    input  logic [XLEN-1:0]     i_mem_fwd_data,
    input  logic                i_wb_fwd_en,
    input  logic [REG_W-1:0]    i_wb_fwd_rd,
    input  logic [XLEN-1:0]     i_wb_fwd_data,
    ch0re_alu_intf.initiator    alu,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    output logic [XLEN-1:0]     o_mem_res,
    output logic [XLEN-1:0]     o_mem_store_data,
    output logic [REG_W-1:0]    o_mem_rd,
    output logic                o_mem_wb_en,
    output logic                o_redirect,
    output logic [XLEN-1:0]     o_redirect_pc
);

    // MEM beats WB beats register file; x0 is hard-wired to zero.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_W-1:0] idx,
        input logic [XLEN-1:0]  rf_val,
        input logic             mem_en,
        input logic [REG_W-1:0] mem_rd,
        input logic [XLEN-1:0]  mem_data,
        input logic             wb_en,
        input logic [REG_W-1:0] wb_rd,
        input logic [XLEN-1:0]  wb_data
    );
        logic [XLEN-1:0] val;
        val = rf_val;
        if (idx == REG_W'(0)) begin
            val = '0;
        end else if (mem_en && (mem_rd == idx)) begin
            val = mem_data;
        end else if (wb_en && (wb_rd == idx)) begin
            val = wb_data;
        end
        return val;
    endfunction

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;
    logic [XLEN-1:0] link_addr;
    logic            br_cond;
    logic            take;
    logic            accept;
    logic            load;

    always_comb begin
        rs1_val = fwd_sel(i_id_rs1_idx, i_id_rs1, i_mem_fwd_en, i_mem_fwd_rd, i_mem_fwd_data,
                          i_wb_fwd_en, i_wb_fwd_rd, i_wb_fwd_data);
        rs2_val = fwd_sel(i_id_rs2_idx, i_id_rs2, i_mem_fwd_en, i_mem_fwd_rd, i_mem_fwd_data,
                          i_wb_fwd_en, i_wb_fwd_rd, i_wb_fwd_data);
    end

    assign alu.i_op = i_id_op;
    assign alu.i_s1 = i_id_src1_pc  ? i_id_pc  : rs1_val;
    assign alu.i_s2 = i_id_src2_imm ? i_id_imm : rs2_val;

    // Branch condition from ALU flags; signedness is the ALU's concern.
    always_comb begin
        br_cond = 1'b0;
        case (i_id_op)
            ALU_EQ:           br_cond = alu.o_flag_zero;
            ALU_NE:           br_cond = !alu.o_flag_zero;
            ALU_LT, ALU_LTU:  br_cond = alu.o_flag_lt;
            ALU_GE, ALU_GEU:  br_cond = !alu.o_flag_lt;
            default:          br_cond = 1'b0;
        endcase
    end

    assign br_target  = i_id_pc + i_id_imm;
    assign jmp_target = {alu.o_res[XLEN-1:1], 1'b0};
    assign link_addr  = i_id_pc + XLEN'(4);
    assign take       = i_id_is_jump || (i_id_is_branch && br_cond);

    assign o_id_ready = !o_mem_valid || i_mem_ready;
    assign accept     = i_id_valid && o_id_ready;
    // While the redirect pulse is high the accepted instruction is wrong-path.
    assign load       = accept && !o_redirect;

    // EX/MEM pipeline register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_valid      <= 1'b0;
            o_mem_res        <= '0;
            o_mem_store_data <= '0;
            o_mem_rd         <= '0;
            o_mem_wb_en      <= 1'b0;
        end else if (load) begin
            o_mem_valid      <= 1'b1;
            o_mem_res        <= i_id_is_jump ? link_addr : alu.o_res;
            o_mem_store_data <= rs2_val;
            o_mem_rd         <= i_id_rd;
            o_mem_wb_en      <= i_id_wb_en && !i_id_is_branch;
        end else if (i_mem_ready) begin
            o_mem_valid      <= 1'b0;
        end
    end

    // Redirect pulse; the target register keeps its last value afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
        end else begin
            o_redirect <= load && take;
            if (load && take) begin
                o_redirect_pc <= i_id_is_jump ? jmp_target : br_target;
            end
        end
    end

endmodule

// File: doc/ch0re_ex_stage.md
# ch0re_ex_stage

Execute-stage controller of the ch0re pipeline. It is the initiator side of the `ch0re_alu_intf` interface. It accepts decoded instructions from the ID stage over a valid/ready handshake and resolves operands through MEM/WB forwarding. It drives the ALU, resolves branches and jumps from the ALU flags, and registers the result into the EX/MEM pipeline register. Taken control transfers produce a one-cycle front-end redirect.

## Interface
- `XLEN`, 64, datapath width. Only 64 is supported.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_id_valid` in 1 / `o_id_ready` out 1  ID→EX handshake.
- `i_id_op`  in  `alu_op_e`  ALU operation.
- `i_id_pc`, `i_id_rs1`, `i_id_rs2`, `i_id_imm`  in  64 each  instruction PC, register-file values, sign-extended immediate.
- `i_id_rs1_idx`, `i_id_rs2_idx`, `i_id_rd`  in  5 each  register indices.
- `i_id_src1_pc`  in  1  s1 = PC instead of rs1.
- `i_id_src2_imm`  in  1  s2 = imm instead of rs2.
- `i_id_is_branch`, `i_id_is_jump`, `i_id_wb_en`  in  1 each  instruction class and write-back enable.
- `i_mem_fwd_en`, `i_mem_fwd_rd`(5), `i_mem_fwd_data`(64)  in  forwarding source from the MEM stage.
- `i_wb_fwd_en`, `i_wb_fwd_rd`(5), `i_wb_fwd_data`(64)  in  forwarding source from the WB stage.
- `alu`  `ch0re_alu_intf`  this block drives `i_op`, `i_s1`, `i_s2` and reads `o_res`, `o_flag_zero`, `o_flag_lt`.
- `o_mem_valid` out 1 / `i_mem_ready` in 1  EX→MEM handshake.
- `o_mem_res`  out 64  ALU result, or link address for jumps.
- `o_mem_store_data`  out 64  forwarded rs2 value.
- `o_mem_rd`  out 5, `o_mem_wb_en`  out 1.
- `o_redirect`  out 1, `o_redirect_pc`  out 64  front-end redirect pulse and target.

## Operation
- **Forwarding** applies per source and is purely combinational. Priority is MEM over WB over register file. A source forwards only if its enable is set, its rd equals the index, and the index is not 0. x0 always reads 0 regardless of inputs.
- **ALU operands:** `alu.i_s1` = `i_id_src1_pc` ? PC : fwd_rs1. `alu.i_s2` = `i_id_src2_imm` ? imm : fwd_rs2. `alu.i_op` = `i_id_op`.
- **Branches** (`i_id_is_branch`, op ∈ EQ/NE/LT/GE/LTU/GEU, both operands registers):
  - taken = EQ: zero; NE: !zero; LT/LTU: lt; GE/GEU: !lt.
  - target = PC + imm (local 64-bit adder, wraps mod 2^64).
  - `o_mem_wb_en` is forced 0.
- **Jumps** (`i_id_is_jump`, op = ADD): always taken. target = ALU result with bit 0 cleared. `o_mem_res` = PC + 4 (wraps mod 2^64).
- **Other instructions:** `o_mem_res` = `alu.o_res`; no redirect.
- **Accept condition:** accept = `i_id_valid` && `o_id_ready`. `o_id_ready` = !`o_mem_valid` || `i_mem_ready` (combinational).
- **Shadow squash:** in the cycle `o_redirect` = 1, an accepted instruction is a wrong-path instruction. It is consumed and discarded: no EX/MEM write, `o_mem_valid` falls if the downstream handshake completes, and no further redirect is generated.
- **State:**
  - EX/MEM register.
  - `o_redirect` / `o_redirect_pc` register.
  - `shadow` = `o_redirect`; no separate FSM.
  - Effective states are IDLE (`o_mem_valid`=0), HOLD (`o_mem_valid`=1, `i_mem_ready`=0) and FLOW.

## Timing
- **Reset** (asynchronous, `i_rst_n`=0): `o_mem_valid`, `o_mem_res`, `o_mem_store_data`, `o_mem_rd`, `o_mem_wb_en`, `o_redirect` and `o_redirect_pc` all go to 0 immediately. A reset mid-instruction drops it; there is no partial state.
- **Latency:** 1 cycle. An instruction accepted at edge N appears on `o_mem_*` after edge N.
- **Stall:** while `o_mem_valid`=1 and `i_mem_ready`=0, all `o_mem_*` outputs hold stable and `o_id_ready`=0.
- **Redirect:**
  - `o_redirect` goes to 1 for exactly one cycle after the edge that accepts a taken branch or jump.
  - It is independent of downstream stall; the redirect fires even if MEM stalls afterwards.
  - `o_redirect_pc` holds the target during that cycle and keeps its last value after.
- **Simultaneous events:** a taken branch and a downstream stall produce the redirect pulse while the branch sits in HOLD. Back-to-back accepted instructions without bubbles are required when `i_mem_ready`=1.
- **Combinational paths:** the ALU path (`i_id_*`/fwd → `alu` → EX/MEM D-input) and `i_mem_ready` → `o_id_ready` are combinational. There is no other combinational path from input to output.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-stream → all outputs 0 asynchronously. After release, the first accepted ADD (rs1=5, rs2=7) → `o_mem_res`=12, rd/wb_en propagated.
- **Forwarding:**
  - rs1_idx=3 with MEM fwd rd=3 data=0x10 and WB fwd rd=3 data=0x20 → s1=0x10.
  - rs1_idx=0 with MEM fwd rd=0 → s1=0.
- **Branch:**
  - BEQ rs1=rs2=9, PC=0x100, imm=-8 → `o_redirect`=1 for one cycle, `o_redirect_pc`=0xF8, `o_mem_wb_en`=0.
  - The instruction accepted in the next cycle is squashed.
- **Signed vs unsigned:**
  - BLT rs1=-1, rs2=1 → taken.
  - BLTU same operands → not taken, no redirect.
- **Jump:** JALR with PC=0x200, rs1=0x1001, imm=4 → `o_redirect_pc`=0x1004, `o_mem_res`=0x204.
- **Backpressure:** hold `i_mem_ready`=0 for 3 cycles with `o_mem_valid`=1 → `o_id_ready`=0 and outputs stable. Release → next instruction accepted that same cycle, with no loss or duplication.
